// File: rtl/mdu_issue_ctrl.sv
// Issue/retire sequencer for the shared MulDivUnit: decodes MDU-class ops, drives the
// unit handshake, owns architectural HI/LO and raises the E-stage stall while busy.
module mdu_issue_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op_code,
  input  logic [31:0]      src_a,
  input  logic [31:0]      src_b,
  input  logic             req,
  output logic             stall,
  output logic [31:0]      rd_data,
  output logic [31:0]      mdu_src0,
  output logic [31:0]      mdu_src1,
  output logic [1:0]       mdu_op,
  output logic             mdu_sign,
  output logic             mdu_in_valid,
  input  logic             mdu_in_ready,
  input  logic             mdu_out_valid,
  output logic             mdu_out_ready,
  input  logic [31:0]      mdu_res0,
  input  logic [31:0]      mdu_res1,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output logic [CNT_W-1:0] busy_cycles
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [1:0] MDU_IDLE = 2'b00;
  localparam logic [1:0] MDU_MUL  = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      src0_q, src0_d;
  logic [31:0]      src1_q, src1_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_idle;
  logic is_mdu_class;
  logic accept;

  assign is_idle      = (state_q == S_IDLE);
  assign is_mdu_class = (op_code >= OP_MULT) && (op_code <= OP_MFLO);
  // Stall never applies in IDLE, so the accepting cycle itself never stalls.
  assign stall        = !is_idle && op_valid && is_mdu_class;
  assign accept       = is_idle && op_valid && !req;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    op_d    = op_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_code)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d = S_ISSUE;
              src0_d  = src_a;
              src1_d  = src_b;
              op_d    = (op_code == OP_MULT || op_code == OP_MULTU) ? MDU_MUL : MDU_DIV;
              sign_d  = (op_code == OP_MULT || op_code == OP_DIV);
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        if (mdu_in_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mdu_out_valid) begin
          hi_d    = mdu_res1;
          lo_d    = mdu_res0;
          op_d    = MDU_IDLE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!is_idle && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      op_q    <= MDU_IDLE;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moves from HI/LO read the registered value, so an MT one cycle earlier is visible.
  always_comb begin
    rd_data = '0;
    if (op_valid && !req && !stall) begin
      if (op_code == OP_MFHI)      rd_data = hi_q;
      else if (op_code == OP_MFLO) rd_data = lo_q;
    end
  end

  assign mdu_src0      = src0_q;
  assign mdu_src1      = src1_q;
  assign mdu_op        = op_q;
  assign mdu_sign      = sign_q;
  assign mdu_in_valid  = (state_q == S_ISSUE);
  assign mdu_out_ready = (state_q == S_WAIT);
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign busy_cycles   = cnt_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: transaction-level model checked every cycle,
// plus hand-computed literal checks on the key scenarios.
module tb_mdu_issue_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             op_valid;
  logic [3:0]       op_code;
  logic [31:0]      src_a;
  logic [31:0]      src_b;
  logic             req;
  logic             stall;
  logic [31:0]      rd_data;
  logic [31:0]      mdu_src0;
  logic [31:0]      mdu_src1;
  logic [1:0]       mdu_op;
  logic             mdu_sign;
  logic             mdu_in_valid;
  logic             mdu_in_ready;
  logic             mdu_out_valid;
  logic             mdu_out_ready;
  logic [31:0]      mdu_res0;
  logic [31:0]      mdu_res1;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [CNT_W-1:0] busy_cycles;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .src_a        (src_a),
    .src_b        (src_b),
    .req          (req),
    .stall        (stall),
    .rd_data      (rd_data),
    .mdu_src0     (mdu_src0),
    .mdu_src1     (mdu_src1),
    .mdu_op       (mdu_op),
    .mdu_sign     (mdu_sign),
    .mdu_in_valid (mdu_in_valid),
    .mdu_in_ready (mdu_in_ready),
    .mdu_out_valid(mdu_out_valid),
    .mdu_out_ready(mdu_out_ready),
    .mdu_res0     (mdu_res0),
    .mdu_res1     (mdu_res1),
    .hi           (hi),
    .lo           (lo),
    .busy_cycles  (busy_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: one outstanding operation record plus HI/LO and a saturating busy count.
  bit          m_init = 1'b0;
  bit          m_busy, m_issued, m_signed;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [1:0]  m_kind;
  int          m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_init   <= 1'b1;
      m_busy   <= 1'b0;
      m_issued <= 1'b0;
      m_hi     <= '0;
      m_lo     <= '0;
      m_cnt    <= 0;
    end else if (m_busy) begin
      if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (!m_issued) begin
        if (mdu_in_ready) m_issued <= 1'b1;
      end else if (mdu_out_valid) begin
        m_hi   <= mdu_res1;
        m_lo   <= mdu_res0;
        m_busy <= 1'b0;
      end
    end else if (op_valid && !req) begin
      if (op_code >= 4'd1 && op_code <= 4'd4) begin
        m_busy   <= 1'b1;
        m_issued <= 1'b0;
        m_a      <= src_a;
        m_b      <= src_b;
        m_kind   <= (op_code <= 4'd2) ? 2'b01 : 2'b10;
        m_signed <= (op_code == 4'd1 || op_code == 4'd3);
      end else if (op_code == 4'd5) begin
        m_hi <= src_a;
      end else if (op_code == 4'd6) begin
        m_lo <= src_a;
      end
    end
  end

  logic        e_stall;
  logic [31:0] e_rd;
  assign e_stall = m_busy && op_valid && (op_code >= 4'd1) && (op_code <= 4'd8);
  assign e_rd    = (!op_valid || req || e_stall) ? 32'h0 :
                   (op_code == 4'd7) ? m_hi :
                   (op_code == 4'd8) ? m_lo : 32'h0;

  always @(negedge clk) begin
    if (m_init) begin
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("rd_data", rd_data, e_rd);
      chk("in_valid", {31'b0, mdu_in_valid}, {31'b0, m_busy && !m_issued});
      chk("out_ready", {31'b0, mdu_out_ready}, {31'b0, m_busy && m_issued});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("busy_cycles", {{(32-CNT_W){1'b0}}, busy_cycles}, 32'(m_cnt));
      chk("mdu_op", {30'b0, mdu_op}, m_busy ? {30'b0, m_kind} : 32'h0);
      if (m_busy && !m_issued) begin
        chk("src0", mdu_src0, m_a);
        chk("src1", mdu_src1, m_b);
        chk("sign", {31'b0, mdu_sign}, {31'b0, m_signed});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 4'd0; src_a = '0; src_b = '0; req = 1'b0;
    mdu_in_ready = 1'b0; mdu_out_valid = 1'b0; mdu_res0 = '0; mdu_res1 = '0;

    // Reset for two cycles
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_in_valid", {31'b0, mdu_in_valid}, 32'h0);
    chk("rst_busy", {28'b0, busy_cycles}, 32'h0);
    chk("rst_rd", rd_data, 32'h0);

    // MULT 0xFFFFFFFF * 2
    op_valid = 1'b1; op_code = 4'd1; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    #1 chk("mult_accept_nostall", {31'b0, stall}, 32'h0);
    tick();
    op_valid = 1'b0;
    #1;
    chk("mult_in_valid", {31'b0, mdu_in_valid}, 32'h1);
    chk("mult_op", {30'b0, mdu_op}, 32'h1);
    chk("mult_sign", {31'b0, mdu_sign}, 32'h1);
    chk("mult_src0", mdu_src0, 32'hFFFF_FFFF);
    mdu_in_ready = 1'b1;
    tick();
    mdu_in_ready = 1'b0;
    op_valid = 1'b1; op_code = 4'd7;
    #1;
    chk("mult_wait_ready", {31'b0, mdu_out_ready}, 32'h1);
    chk("mfhi_wait_stall", {31'b0, stall}, 32'h1);
    chk("mfhi_wait_rd", rd_data, 32'h0);
    tick(); tick(); tick();
    mdu_out_valid = 1'b1; mdu_res1 = 32'hFFFF_FFFF; mdu_res0 = 32'hFFFF_FFFE;
    tick();
    mdu_out_valid = 1'b0;
    #1;
    chk("mfhi_after_rd", rd_data, 32'hFFFF_FFFF);
    chk("mfhi_after_stall", {31'b0, stall}, 32'h0);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    op_valid = 1'b0;

    // DIVU 7/2 with in_ready held low for 3 cycles; stray out_valid in ISSUE
    op_valid = 1'b1; op_code = 4'd4; src_a = 32'd7; src_b = 32'd2;
    tick();
    op_valid = 1'b0; src_a = 32'h0; src_b = 32'h0;
    for (int i = 0; i < 3; i++) begin
      mdu_out_valid = (i == 1); mdu_res0 = 32'hDEAD; mdu_res1 = 32'hBEEF;
      #1;
      chk("divu_in_valid", {31'b0, mdu_in_valid}, 32'h1);
      chk("divu_src0", mdu_src0, 32'd7);
      chk("divu_src1", mdu_src1, 32'd2);
      chk("divu_op", {30'b0, mdu_op}, 32'h2);
      chk("divu_sign", {31'b0, mdu_sign}, 32'h0);
      tick();
    end
    mdu_out_valid = 1'b0;
    mdu_in_ready = 1'b1;
    tick();
    mdu_out_valid = 1'b1; mdu_res1 = 32'd1; mdu_res0 = 32'd3;
    tick();
    mdu_out_valid = 1'b0; mdu_in_ready = 1'b0;
    #1;
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    // MULT flushed by req
    op_valid = 1'b1; op_code = 4'd1; req = 1'b1; src_a = 32'd5; src_b = 32'd6;
    tick();
    op_valid = 1'b0; req = 1'b0;
    #1 chk("req_in_valid", {31'b0, mdu_in_valid}, 32'h0);
    tick();
    chk("req_in_valid2", {31'b0, mdu_in_valid}, 32'h0);
    chk("req_hi", hi, 32'd1);
    chk("req_lo", lo, 32'd3);

    // MTHI then MFHI; MF with req; MTLO flushed by req
    op_valid = 1'b1; op_code = 4'd5; src_a = 32'h1234;
    tick();
    op_code = 4'd7;
    #1 chk("mthi_mfhi", rd_data, 32'h1234);
    req = 1'b1;
    #1 chk("mfhi_req_rd", rd_data, 32'h0);
    op_code = 4'd6; src_a = 32'h55;
    tick();
    req = 1'b0; op_code = 4'd8;
    #1;
    chk("mtlo_req_mflo", rd_data, 32'd3);
    chk("mtlo_req_lo", lo, 32'd3);
    op_valid = 1'b0;

    // Reset while in WAIT, then a late out_valid
    op_valid = 1'b1; op_code = 4'd3; src_a = 32'd100; src_b = 32'd7;
    tick();
    op_code = 4'hF;
    #1 chk("unknown_nostall", {31'b0, stall}, 32'h0);
    op_code = 4'd0;
    #1 chk("zero_nostall", {31'b0, stall}, 32'h0);
    op_valid = 1'b0;
    mdu_in_ready = 1'b1;
    tick();
    mdu_in_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdu_out_valid = 1'b1; mdu_res1 = 32'hAAAA; mdu_res0 = 32'hBBBB;
    tick();
    mdu_out_valid = 1'b0;
    #1;
    chk("rstwait_hi", hi, 32'h0);
    chk("rstwait_lo", lo, 32'h0);
    chk("rstwait_in_valid", {31'b0, mdu_in_valid}, 32'h0);
    chk("rstwait_out_ready", {31'b0, mdu_out_ready}, 32'h0);

    // Saturation of the 4-bit busy counter
    op_valid = 1'b1; op_code = 4'd2; src_a = 32'd3; src_b = 32'd4;
    tick();
    op_valid = 1'b0;
    repeat (20) tick();
    chk("busy_sat", {28'b0, busy_cycles}, 32'hF);
    mdu_in_ready = 1'b1;
    tick();
    mdu_in_ready = 1'b0;
    mdu_out_valid = 1'b1; mdu_res1 = 32'd0; mdu_res0 = 32'd12;
    tick();
    mdu_out_valid = 1'b0;
    #1;
    chk("sat_lo", lo, 32'd12);
    chk("busy_sat_hold", {28'b0, busy_cycles}, 32'hF);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
